// File: rtl/vga_bank_scheduler.sv
// Ping-pong frame-buffer bank scheduler: the writer fills one bank while the display reads
// the other; banks swap only on a vsync edge once the writer has finished. Optional
// FRAME_SKIP_CNT_EN adds a saturating SKIP_CNT output counting repeated frames.
module vga_bank_scheduler #(
    parameter int CNT_W  = 2,
    parameter bit VS_POL = 1'b0
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             VSYNC_IN,
    input  logic             WR_DONE,
    output logic             WR_EN,
    output logic             SEL_RD1,
    output logic             SEL_RD0,
    output logic             SEL_WR1,
    output logic             SEL_WR0,
    output logic             SWAP,
    output logic [CNT_W-1:0] FRAME_CNT
`ifdef FRAME_SKIP_CNT_EN
    ,
    output logic [7:0]       SKIP_CNT
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_WAIT = 2'd2,
        S_SWAP = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             vs_q;
    logic             vs_edge;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [1:0]       sel_rd_q, sel_rd_d;
    logic [1:0]       sel_wr_q, sel_wr_d;
    logic             wr_en_q, wr_en_d;
    logic             swap_q, swap_d;

    // An edge is the first cycle vsync reaches its active level.
    assign vs_edge = (VSYNC_IN == VS_POL) && (vs_q != VS_POL);

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        swap_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (vs_edge) begin
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (WR_DONE && vs_edge) begin
                    state_d = S_SWAP;
                end else if (WR_DONE) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (vs_edge) begin
                    state_d = S_SWAP;
                end
            end
            S_SWAP: begin
                state_d = S_FILL;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Counter, selects and the swap pulse all change on entry into S_SWAP.
        if (state_d == S_SWAP) begin
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
            swap_d      = 1'b1;
        end

        wr_en_d  = (state_d == S_FILL);
        sel_rd_d = frame_cnt_d[0] ? 2'b01 : 2'b10;
        sel_wr_d = ~sel_rd_d;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            vs_q        <= ~VS_POL;
            frame_cnt_q <= '0;
            sel_rd_q    <= 2'b10;
            sel_wr_q    <= 2'b01;
            wr_en_q     <= 1'b0;
            swap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vs_q        <= VSYNC_IN;
            frame_cnt_q <= frame_cnt_d;
            sel_rd_q    <= sel_rd_d;
            sel_wr_q    <= sel_wr_d;
            wr_en_q     <= wr_en_d;
            swap_q      <= swap_d;
        end
    end

`ifdef FRAME_SKIP_CNT_EN
    logic [7:0] skip_cnt_q, skip_cnt_d;

    // A vsync edge while still filling means the display repeats the current bank.
    always_comb begin
        skip_cnt_d = skip_cnt_q;
        if ((state_q == S_FILL) && vs_edge && !WR_DONE && (skip_cnt_q != 8'hFF)) begin
            skip_cnt_d = skip_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            skip_cnt_q <= 8'd0;
        end else begin
            skip_cnt_q <= skip_cnt_d;
        end
    end

    assign SKIP_CNT = skip_cnt_q;
`endif

    assign WR_EN     = wr_en_q;
    assign SWAP      = swap_q;
    assign FRAME_CNT = frame_cnt_q;
    assign SEL_RD1   = sel_rd_q[1];
    assign SEL_RD0   = sel_rd_q[0];
    assign SEL_WR1   = sel_wr_q[1];
    assign SEL_WR0   = sel_wr_q[0];

endmodule
